// File: rtl/systolic_drain.sv
// systolic_drain: shifts DIM accumulator rows out of the array and streams them element by element.
// Optional macro SYSTOLIC_DRAIN_OVR_EN adds a sticky `ovr` output flagging a start seen while busy.
module systolic_drain #(
  parameter int DIM = 8,
  parameter int DW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl,
  input  logic [DIM*DW-1:0] row_in,
  output logic              shift_en,
  output logic [DW-1:0]     m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
`ifdef SYSTOLIC_DRAIN_OVR_EN
  output logic              ovr,
`endif
  output logic [1:0]        dbg_state
);

  localparam int RW = $clog2(DIM + 1);
  localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [DIM*DW-1:0] hold_q, hold_d;
  logic              ctrl_q;
  logic              start;
  logic              xfer;

  logic              shift_en_q, shift_en_d;
  logic [DW-1:0]     m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Stream handshake: an element moves when m_valid & m_ready at a rising edge;
  // while m_valid is high and m_ready low, m_data/m_last hold and m_valid stays up.
  assign start = ctrl_q & ~ctrl;
  assign xfer  = m_valid_q & m_ready;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        hold_d  = row_in;
        row_d   = row_q + RW'(1);
        col_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (xfer) begin
          if (col_q == CW'(DIM - 1)) begin
            state_d = (row_q == RW'(DIM)) ? DONE : LOAD;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DONE: begin
        row_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned with state_q.
    shift_en_d = (state_d == LOAD);
    m_valid_d  = (state_d == SEND);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    m_last_d   = (state_d == SEND) && (row_d == RW'(DIM)) && (col_d == CW'(DIM - 1));
    m_data_d   = '0;
    if (state_d == SEND) begin
      for (int c = 0; c < DIM; c++) begin
        if (col_d == CW'(c)) m_data_d = hold_d[c*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      hold_q     <= '0;
      ctrl_q     <= 1'b0;
      shift_en_q <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      hold_q     <= hold_d;
      ctrl_q     <= ctrl;
      shift_en_q <= shift_en_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef SYSTOLIC_DRAIN_OVR_EN
  logic ovr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovr_q <= 1'b0;
    end else if (start && (state_q != IDLE)) begin
      ovr_q <= 1'b1;
    end
  end

  assign ovr = ovr_q;
`endif

  assign shift_en  = shift_en_q;
  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain (DIM=4, DW=16): a shifting-array model feeds row_in, a negedge monitor records the stream.
module tb_systolic_drain;

  localparam int DIM = 4;
  localparam int DW  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ctrl = 1'b0;
  logic              m_ready = 1'b0;
  logic [DIM*DW-1:0] row_in;
  logic              shift_en, m_valid, m_last, busy, done;
  logic [DW-1:0]     m_data;
  logic [1:0]        dbg_state;
`ifdef SYSTOLIC_DRAIN_OVR_EN
  logic              ovr;
`endif

  int checks = 0;
  int failures = 0;

  // Array model: element c of the current bottom row is {tag, row, 4'h0, c}.
  logic [3:0] tag = 4'h0;
  logic [3:0] ptr = 4'h0;
  logic       tb_clr = 1'b0;
  logic       shift_pend = 1'b0;
  logic       mon_clr = 1'b0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic          last_q[$];
  int shift_cnt = 0;
  int done_cnt = 0;
  int viol_cnt = 0;

  systolic_drain #(.DIM(DIM), .DW(DW)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .row_in(row_in),
    .shift_en(shift_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .done(done),
`ifdef SYSTOLIC_DRAIN_OVR_EN
    .ovr(ovr),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_in = '0;
    for (int c = 0; c < DIM; c++) row_in[c*DW +: DW] = {tag, ptr, 4'h0, 4'(c)};
  end

  always @(posedge clk) begin
    if (tb_clr) ptr <= 4'h0;
    else if (shift_pend) ptr <= ptr + 4'h1;
  end

  always @(negedge clk) begin
    if (mon_clr) begin
      got_q.delete(); last_q.delete();
      shift_cnt = 0; done_cnt = 0; viol_cnt = 0; shift_pend = 1'b0;
    end else begin
      shift_pend = rst && shift_en;
      if (rst) begin
        if (m_valid && m_ready) begin
          got_q.push_back(m_data);
          last_q.push_back(m_last);
        end
        if (shift_en) shift_cnt++;
        if (done) done_cnt++;
        if (shift_en && m_valid) viol_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_all();
    mon_clr = 1'b1; tb_clr = 1'b1;
    step();
    mon_clr = 1'b0; tb_clr = 1'b0;
  endtask

  task automatic fill_exp(input logic [3:0] t);
    exp_q.delete();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) exp_q.push_back({t, 4'(r), 4'h0, 4'(c)});
  endtask

  // Scoreboard: count order/last-flag errors between recorded stream and exp_q.
  function automatic int stream_errs();
    int e = 0;
    if (got_q.size() != exp_q.size()) e++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) e++;
      if (last_q[i] !== (i == exp_q.size() - 1)) e++;
    end
    return e;
  endfunction

  task automatic start_drain();
    ctrl = 1'b1;
    step();
    ctrl = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, inout int k);
    while (k < budget && done !== 1'b1) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
  endtask

  task automatic test_reset();
    int k = 0;
    bit bad = 0;
    rst = 1'b0; ctrl = 1'b0; m_ready = 1'b1;
    step(); step();
    checks++;
    if ({busy, m_valid, shift_en, done, m_last} !== 5'b0 || m_data !== 16'h0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b data=%h state=%0d exp=0", {busy, m_valid, shift_en, done, m_last}, m_data, dbg_state);
    end
`ifdef SYSTOLIC_DRAIN_OVR_EN
    checks++;
    if (ovr !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", ovr); end
`endif
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (busy !== 1'b0 || m_valid !== 1'b0 || shift_en !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL release_idle got=active exp=idle"); end
    clear_all(); tag = 4'h0; fill_exp(4'h0);
    start_drain();
    wait_done(60, 0, k);
    step();
    checks++;
    if (stream_errs() !== 0 || done_cnt !== 1) begin
      failures++; $display("FAIL reset_first_drain got errs=%0d dones=%0d exp 0/1", stream_errs(), done_cnt);
    end
  endtask

  task automatic test_basic();
    int k = 0;
    clear_all(); tag = 4'h0; fill_exp(4'h0); m_ready = 1'b1;
    start_drain();
    step(); k++;
    checks++;
    if (shift_en !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL basic_load got shift=%b valid=%b busy=%b exp 1/0/1", shift_en, m_valid, busy);
    end
    step(); k++;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'h0000 || shift_en !== 1'b0) begin
      failures++; $display("FAIL basic_first_valid got valid=%b data=%h exp 1/0000", m_valid, m_data);
    end
    wait_done(60, 0, k);
    checks++;
    if (done !== 1'b1 || k !== 21) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=21", k); end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      failures++; $display("FAIL basic_after_done got done=%b busy=%b state=%0d exp 0/0/0", done, busy, dbg_state);
    end
    checks++;
    if (stream_errs() !== 0) begin failures++; $display("FAIL basic_order got errs=%0d exp=0", stream_errs()); end
    checks++;
    if (shift_cnt !== 4 || done_cnt !== 1 || viol_cnt !== 0) begin
      failures++; $display("FAIL basic_counts got shifts=%0d dones=%0d viol=%0d exp 4/1/0", shift_cnt, done_cnt, viol_cnt);
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    bit stalled = 0;
    bit bad = 0;
    clear_all(); tag = 4'h0; fill_exp(4'h0); m_ready = 1'b1;
    start_drain();
    while (k < 60 && done !== 1'b1) begin
      if (!stalled && m_valid === 1'b1 && m_data === 16'h0102) begin
        stalled = 1; m_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          if (m_valid !== 1'b1 || m_data !== 16'h0102 || shift_en !== 1'b0) bad = 1;
          step(); k++;
        end
        m_ready = 1'b1;
      end else begin
        step(); k++;
      end
    end
    checks++;
    if (!stalled || bad) begin failures++; $display("FAIL bp_hold got stalled=%0d bad=%0d exp 1/0", stalled, bad); end
    checks++;
    if (done !== 1'b1 || k !== 26) begin failures++; $display("FAIL bp_done_cycle got=%0d exp=26", k); end
    step();
    checks++;
    if (stream_errs() !== 0 || shift_cnt !== 4) begin
      failures++; $display("FAIL bp_order got errs=%0d shifts=%0d exp 0/4", stream_errs(), shift_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    bit found = 0;
    clear_all(); tag = 4'h1; m_ready = 1'b1;
    start_drain();
    while (k < 40 && !found) begin
      step(); k++;
      if (m_valid === 1'b1 && m_data === 16'h1201) found = 1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL mid_reach got=not_seen exp=1201"); end
    rst = 1'b0;
    step();
    checks++;
    if ({busy, m_valid, shift_en, done, m_last} !== 5'b0 || m_data !== 16'h0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%b data=%h state=%0d exp=0", {busy, m_valid, shift_en, done, m_last}, m_data, dbg_state);
    end
    rst = 1'b1;
    repeat (25) step();
    checks++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      failures++; $display("FAIL mid_no_done got dones=%0d busy=%b exp 0/0", done_cnt, busy);
    end
    clear_all(); fill_exp(4'h1); k = 0;
    start_drain();
    wait_done(60, 0, k);
    step();
    checks++;
    if (stream_errs() !== 0 || k !== 21 || done_cnt !== 1) begin
      failures++; $display("FAIL mid_restart got errs=%0d cyc=%0d dones=%0d exp 0/21/1", stream_errs(), k, done_cnt);
    end
  endtask

  task automatic test_start_busy();
    int k = 0;
    bit found = 0;
    clear_all(); tag = 4'h2; fill_exp(4'h2); m_ready = 1'b1;
    start_drain();
    while (k < 40 && !found) begin
      step(); k++;
      if (m_valid === 1'b1 && m_data === 16'h2100) found = 1;
    end
    ctrl = 1'b1;
    step(); k++;
    ctrl = 1'b0;
    step(); k++;
`ifdef SYSTOLIC_DRAIN_OVR_EN
    checks++;
    if (ovr !== 1'b1) begin failures++; $display("FAIL busy_ovr_set got=%b exp=1", ovr); end
`endif
    wait_done(60, 0, k);
    repeat (3) step();
    checks++;
    if (!found || k !== 21) begin failures++; $display("FAIL busy_done_cycle got=%0d exp=21", k); end
    checks++;
    if (stream_errs() !== 0 || done_cnt !== 1 || shift_cnt !== 4 || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_single_drain got errs=%0d dones=%0d shifts=%0d busy=%b exp 0/1/4/0", stream_errs(), done_cnt, shift_cnt, busy);
    end
`ifdef SYSTOLIC_DRAIN_OVR_EN
    checks++;
    if (ovr !== 1'b1) begin failures++; $display("FAIL busy_ovr_sticky got=%b exp=1", ovr); end
`endif
  endtask

  task automatic test_random_ready();
    for (int d = 0; d < 3; d++) begin
      int k = 0;
      clear_all(); tag = 4'(4 + d); fill_exp(4'(4 + d));
      start_drain();
      wait_done(300, 1, k);
      checks++;
      if (done !== 1'b1) begin failures++; $display("FAIL rand_timeout drain=%0d got=no_done exp=done", d); end
      m_ready = 1'b1;
      step();
      checks++;
      if (stream_errs() !== 0 || shift_cnt !== 4 || done_cnt !== 1 || viol_cnt !== 0) begin
        failures++;
        $display("FAIL rand_drain%0d got errs=%0d shifts=%0d dones=%0d viol=%0d exp 0/4/1/0", d, stream_errs(), shift_cnt, done_cnt, viol_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_start_busy();
    test_random_ready();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
